// File: rtl/arbiter_response_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : arbiter_response_ctrl
// Description : Control and return path of the I/D-cache to L2 arbiter.
//               Grants one cache at a time and steers the datapath with
//               arbiter_sel. Gates L2 read/write requests and captures L2
//               read data. Returns a one-cycle resp to the granted cache.
// Revision    : 1.0 - initial release
// ============================================================================
module arbiter_response_ctrl #(
  parameter int DATA_WIDTH = 128,
  parameter bit RR_EN      = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_pmem_read,
  input  logic                  i_pmem_write,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic                  l2_mem_resp,
  input  logic [DATA_WIDTH-1:0] l2_mem_rdata,
  output logic                  arbiter_sel,
  output logic                  l2_mem_read,
  output logic                  l2_mem_write,
  output logic                  i_pmem_resp,
  output logic [DATA_WIDTH-1:0] i_pmem_rdata,
  output logic                  d_pmem_resp,
  output logic [DATA_WIDTH-1:0] d_pmem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic c_GRANT_I = 1'b0;
  localparam logic c_GRANT_D = 1'b1;

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_last_grant;
  logic                  w_next_grant;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  w_capture;
  logic                  w_i_pending;
  logic                  w_d_pending;
  logic                  w_tie_to_d;
  logic                  w_pick_d;

  assign w_i_pending = i_pmem_read | i_pmem_write;
  assign w_d_pending = d_pmem_read | d_pmem_write;

  // Tie-break policy: alternate against the previous winner, or favour D
  generate
    if (RR_EN) begin : g_round_robin
      assign w_tie_to_d = (r_last_grant == c_GRANT_I);
    end else begin : g_d_priority
      assign w_tie_to_d = 1'b1;
    end
  endgenerate

  assign w_pick_d = w_d_pending & (~w_i_pending | w_tie_to_d);

  // State, grant history and captured read data registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_last_grant <= c_GRANT_I;
      r_rdata      <= '0;
    end else begin
      r_state      <= w_next_state;
      r_last_grant <= w_next_grant;
      if (w_capture) begin
        r_rdata <= l2_mem_rdata;
      end
    end
  end

  // Next-state, grant selection and capture strobe
  always_comb begin
    w_next_state = r_state;
    w_next_grant = r_last_grant;
    w_capture    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_d) begin
          w_next_state = D_BUSY;
          w_next_grant = c_GRANT_D;
        end else if (w_i_pending) begin
          w_next_state = I_BUSY;
          w_next_grant = c_GRANT_I;
        end
      end
      I_BUSY, D_BUSY: begin
        // L2 completion only matters while a transaction is outstanding
        if (l2_mem_resp) begin
          w_capture    = 1'b1;
          w_next_state = DONE;
        end
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // L2 request gating and completion pulses to the caches
  always_comb begin
    l2_mem_read  = 1'b0;
    l2_mem_write = 1'b0;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;
    case (r_state)
      I_BUSY: begin
        l2_mem_read  = i_pmem_read;
        l2_mem_write = i_pmem_write;
      end
      D_BUSY: begin
        l2_mem_read  = d_pmem_read;
        l2_mem_write = d_pmem_write;
      end
      DONE: begin
        // Requests are still held here, so L2 is deliberately not driven
        i_pmem_resp = (r_last_grant == c_GRANT_I);
        d_pmem_resp = (r_last_grant == c_GRANT_D);
      end
      default: begin
      end
    endcase
  end

  // Select follows the most recent grant so the datapath never glitches in IDLE
  assign arbiter_sel  = r_last_grant;
  assign i_pmem_rdata = r_rdata;
  assign d_pmem_rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_arbiter_response_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_arbiter_response_ctrl
// Description : Self-checking bench for arbiter_response_ctrl. A round-robin
//               instance and a D-priority instance share all inputs; the
//               round-robin instance is also run against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arbiter_response_ctrl;

  localparam int DW = 128;

  logic          clk;
  logic          reset_n;
  logic          i_pmem_read, i_pmem_write, d_pmem_read, d_pmem_write;
  logic          l2_mem_resp;
  logic [DW-1:0] l2_mem_rdata;

  logic          arbiter_sel, l2_mem_read, l2_mem_write;
  logic          i_pmem_resp, d_pmem_resp;
  logic [DW-1:0] i_pmem_rdata, d_pmem_rdata;

  logic          f_arbiter_sel, f_l2_mem_read, f_l2_mem_write;
  logic          f_i_pmem_resp, f_d_pmem_resp;
  logic [DW-1:0] f_i_pmem_rdata, f_d_pmem_rdata;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    logic          sel, rd, wr;
    bit            stable;
    logic          f_sel;
    logic          iresp, dresp, dn_rd, dn_wr, dn_sel;
    logic [DW-1:0] irdata, drdata;
    logic          f_iresp, f_dresp;
  } obs_t;

  arbiter_response_ctrl #(.DATA_WIDTH(DW), .RR_EN(1'b1)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_pmem_read(i_pmem_read), .i_pmem_write(i_pmem_write),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .l2_mem_resp(l2_mem_resp), .l2_mem_rdata(l2_mem_rdata),
    .arbiter_sel(arbiter_sel), .l2_mem_read(l2_mem_read), .l2_mem_write(l2_mem_write),
    .i_pmem_resp(i_pmem_resp), .i_pmem_rdata(i_pmem_rdata),
    .d_pmem_resp(d_pmem_resp), .d_pmem_rdata(d_pmem_rdata)
  );

  arbiter_response_ctrl #(.DATA_WIDTH(DW), .RR_EN(1'b0)) dut_fixed (
    .clk(clk), .reset_n(reset_n),
    .i_pmem_read(i_pmem_read), .i_pmem_write(i_pmem_write),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .l2_mem_resp(l2_mem_resp), .l2_mem_rdata(l2_mem_rdata),
    .arbiter_sel(f_arbiter_sel), .l2_mem_read(f_l2_mem_read), .l2_mem_write(f_l2_mem_write),
    .i_pmem_resp(f_i_pmem_resp), .i_pmem_rdata(f_i_pmem_rdata),
    .d_pmem_resp(f_d_pmem_resp), .d_pmem_rdata(f_d_pmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Illegal stimulus guard: a cache never reads and writes at once
  always @(posedge clk) begin
    if (reset_n) begin
      assert (!(i_pmem_read && i_pmem_write)) else $error("illegal I read+write");
      assert (!(d_pmem_read && d_pmem_write)) else $error("illegal D read+write");
    end
  end

  task automatic idle_cycle();
    @(negedge clk);
    i_pmem_read = 0; i_pmem_write = 0; d_pmem_read = 0; d_pmem_write = 0;
    l2_mem_resp = 0;
    #1;
  endtask

  // One full transaction: IDLE cycle with given requests, lat+1 BUSY cycles, DONE
  task automatic serve(input logic ir, iw, dr, dw, input int lat,
                       input logic [DW-1:0] data, output obs_t o);
    @(negedge clk);
    i_pmem_read = ir; i_pmem_write = iw; d_pmem_read = dr; d_pmem_write = dw;
    l2_mem_resp = 0; l2_mem_rdata = ~data;
    #1;
    o.stable = 1'b1;
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      l2_mem_resp  = (k == lat);
      l2_mem_rdata = (k == lat) ? data : ~data;
      #1;
      if (k == 0) begin
        o.sel = arbiter_sel; o.rd = l2_mem_read; o.wr = l2_mem_write;
        o.f_sel = f_arbiter_sel;
      end else if (arbiter_sel !== o.sel || l2_mem_read !== o.rd || l2_mem_write !== o.wr) begin
        o.stable = 1'b0;
      end
      if (i_pmem_resp !== 1'b0 || d_pmem_resp !== 1'b0) o.stable = 1'b0;
    end
    @(negedge clk);
    l2_mem_resp = 0; l2_mem_rdata = ~data;
    #1;
    o.iresp = i_pmem_resp; o.dresp = d_pmem_resp;
    o.dn_rd = l2_mem_read; o.dn_wr = l2_mem_write; o.dn_sel = arbiter_sel;
    o.irdata = i_pmem_rdata; o.drdata = d_pmem_rdata;
    o.f_iresp = f_i_pmem_resp; o.f_dresp = f_d_pmem_resp;
  endtask

  task automatic test_reset();
    obs_t o;
    logic [DW-1:0] data_a = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    logic [DW-1:0] data_b = 128'hA5A5_5A5A_0F0F_F0F0_1111_2222_3333_4444;
    reset_n = 0;
    i_pmem_read = 0; i_pmem_write = 0; d_pmem_read = 0; d_pmem_write = 0;
    l2_mem_resp = 0; l2_mem_rdata = '0;
    repeat (3) @(negedge clk);
    reset_n = 1;
    #1;
    n_checks++;
    if ({arbiter_sel, l2_mem_read, l2_mem_write, i_pmem_resp, d_pmem_resp} !== 5'b0 || i_pmem_rdata !== '0) begin
      n_fails++; $display("FAIL reset_values: got %b expected 00000", {arbiter_sel, l2_mem_read, l2_mem_write, i_pmem_resp, d_pmem_resp});
    end
    // Bring the arbiter into D_BUSY, then reset asynchronously mid-cycle
    @(negedge clk); d_pmem_read = 1; #1;
    @(negedge clk); #1;
    n_checks++;
    if (l2_mem_read !== 1'b1 || arbiter_sel !== 1'b1) begin
      n_fails++; $display("FAIL reset_precond_dbusy: got rd=%b sel=%b expected rd=1 sel=1", l2_mem_read, arbiter_sel);
    end
    #2 reset_n = 0;
    #1;
    n_checks++;
    if ({arbiter_sel, l2_mem_read, l2_mem_write, i_pmem_resp, d_pmem_resp} !== 5'b0) begin
      n_fails++; $display("FAIL reset_async: got %b expected 00000", {arbiter_sel, l2_mem_read, l2_mem_write, i_pmem_resp, d_pmem_resp});
    end
    @(negedge clk); d_pmem_read = 0; reset_n = 1; #1;
    // First tie after reset must go to D on both instances
    serve(1, 0, 0, 1, 1, data_a, o);
    n_checks++;
    if (o.sel !== 1'b1 || o.wr !== 1'b1 || o.rd !== 1'b0 || o.f_sel !== 1'b1) begin
      n_fails++; $display("FAIL reset_first_tie: got sel=%b wr=%b rd=%b fsel=%b expected 1 1 0 1", o.sel, o.wr, o.rd, o.f_sel);
    end
    n_checks++;
    if (o.dresp !== 1'b1 || o.iresp !== 1'b0 || o.drdata !== data_a) begin
      n_fails++; $display("FAIL reset_first_tie_resp: got d=%b i=%b data=%h expected 1 0 %h", o.dresp, o.iresp, o.drdata, data_a);
    end
    serve(1, 0, 0, 0, 0, data_b, o);
    n_checks++;
    if (o.sel !== 1'b0 || o.rd !== 1'b1 || o.iresp !== 1'b1 || o.irdata !== data_b) begin
      n_fails++; $display("FAIL reset_then_i: got sel=%b rd=%b iresp=%b data=%h expected 0 1 1 %h", o.sel, o.rd, o.iresp, o.irdata, data_b);
    end
    idle_cycle();
  endtask

  task automatic test_single_i_read();
    logic [DW-1:0] data = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
    @(negedge clk); i_pmem_read = 1; #1;
    n_checks++;
    if (l2_mem_read !== 1'b0 || i_pmem_resp !== 1'b0) begin
      n_fails++; $display("FAIL single_cycle0: got rd=%b resp=%b expected 0 0", l2_mem_read, i_pmem_resp);
    end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      l2_mem_resp  = (c == 3);
      l2_mem_rdata = (c == 3) ? data : '1;
      #1;
      n_checks++;
      if (l2_mem_read !== 1'b1 || l2_mem_write !== 1'b0 || arbiter_sel !== 1'b0 || i_pmem_resp !== 1'b0 || d_pmem_resp !== 1'b0) begin
        n_fails++; $display("FAIL single_busy_c%0d: got rd=%b wr=%b sel=%b ir=%b dr=%b expected 1 0 0 0 0", c, l2_mem_read, l2_mem_write, arbiter_sel, i_pmem_resp, d_pmem_resp);
      end
    end
    @(negedge clk); l2_mem_resp = 0; l2_mem_rdata = '1; #1;
    n_checks++;
    if (i_pmem_resp !== 1'b1 || d_pmem_resp !== 1'b0 || i_pmem_rdata !== data || l2_mem_read !== 1'b0) begin
      n_fails++; $display("FAIL single_done: got ir=%b dr=%b data=%h rd=%b expected 1 0 %h 0", i_pmem_resp, d_pmem_resp, i_pmem_rdata, l2_mem_read, data);
    end
    @(negedge clk); i_pmem_read = 0; #1;
    n_checks++;
    if (i_pmem_resp !== 1'b0 || d_pmem_resp !== 1'b0 || l2_mem_read !== 1'b0) begin
      n_fails++; $display("FAIL single_after: got ir=%b dr=%b rd=%b expected 0 0 0", i_pmem_resp, d_pmem_resp, l2_mem_read);
    end
  endtask

  task automatic test_tie_rr();
    obs_t o;
    logic [DW-1:0] d1 = 128'h1;
    logic [DW-1:0] d2 = 128'h2;
    logic [DW-1:0] d3 = 128'h3;
    serve(1, 0, 0, 1, 0, d1, o);
    n_checks++;
    if (o.sel !== 1'b1 || o.wr !== 1'b1 || o.dresp !== 1'b1 || o.iresp !== 1'b0 || !o.stable) begin
      n_fails++; $display("FAIL tie_rr_first: got sel=%b wr=%b dr=%b ir=%b stable=%b expected 1 1 1 0 1", o.sel, o.wr, o.dresp, o.iresp, o.stable);
    end
    // D re-asserts straight away; I was waiting, so I goes next
    serve(1, 0, 0, 1, 2, d2, o);
    n_checks++;
    if (o.sel !== 1'b0 || o.rd !== 1'b1 || o.wr !== 1'b0 || o.iresp !== 1'b1 || o.dresp !== 1'b0 || o.irdata !== d2 || !o.stable) begin
      n_fails++; $display("FAIL tie_rr_second: got sel=%b rd=%b ir=%b dr=%b data=%h expected 0 1 1 0 %h", o.sel, o.rd, o.iresp, o.dresp, o.irdata, d2);
    end
    n_checks++;
    if (o.f_sel !== 1'b1 || o.f_dresp !== 1'b1) begin
      n_fails++; $display("FAIL tie_fixed_keeps_d: got fsel=%b fdr=%b expected 1 1", o.f_sel, o.f_dresp);
    end
    serve(0, 0, 0, 1, 1, d3, o);
    n_checks++;
    if (o.sel !== 1'b1 || o.dresp !== 1'b1 || o.drdata !== d3 || o.dn_sel !== 1'b1) begin
      n_fails++; $display("FAIL tie_rr_third: got sel=%b dr=%b data=%h dsel=%b expected 1 1 %h 1", o.sel, o.dresp, o.drdata, o.dn_sel, d3);
    end
    idle_cycle();
  endtask

  task automatic test_tie_fixed();
    obs_t o;
    logic [2:0] rr_exp = 3'b010;
    for (int t = 0; t < 3; t++) begin
      serve(1, 0, 1, 0, t, DW'(t + 16), o);
      n_checks++;
      if (o.f_sel !== 1'b1 || o.f_dresp !== 1'b1 || o.f_iresp !== 1'b0) begin
        n_fails++; $display("FAIL fixed_tie_t%0d: got fsel=%b fdr=%b fir=%b expected 1 1 0", t, o.f_sel, o.f_dresp, o.f_iresp);
      end
      n_checks++;
      if (o.sel !== rr_exp[t]) begin
        n_fails++; $display("FAIL rr_alternate_t%0d: got sel=%b expected %b", t, o.sel, rr_exp[t]);
      end
    end
    idle_cycle();
  endtask

  task automatic test_fastest();
    obs_t o;
    logic [DW-1:0] dc = 128'hC0FFEE;
    logic [DW-1:0] dd = 128'hBADC0DE;
    serve(0, 0, 0, 1, 0, dc, o);
    n_checks++;
    if (o.wr !== 1'b1 || !o.stable || o.dresp !== 1'b1 || o.drdata !== dc || o.dn_wr !== 1'b0 || o.dn_sel !== 1'b1) begin
      n_fails++; $display("FAIL fast_d_write: got wr=%b dr=%b data=%h done_wr=%b dsel=%b expected 1 1 %h 0 1", o.wr, o.dresp, o.drdata, o.dn_wr, o.dn_sel, dc);
    end
    serve(1, 0, 0, 0, 0, dd, o);
    n_checks++;
    if (o.rd !== 1'b1 || o.sel !== 1'b0 || o.iresp !== 1'b1 || o.dresp !== 1'b0 || o.irdata !== dd || o.dn_rd !== 1'b0) begin
      n_fails++; $display("FAIL fast_i_read: got rd=%b sel=%b ir=%b dr=%b data=%h done_rd=%b expected 1 0 1 0 %h 0", o.rd, o.sel, o.iresp, o.dresp, o.irdata, o.dn_rd, dd);
    end
    idle_cycle();
  endtask

  task automatic test_spurious_resp();
    obs_t o;
    logic [DW-1:0] last = 128'hBADC0DE;
    logic [DW-1:0] de   = 128'hE0E0;
    @(negedge clk); l2_mem_resp = 1; l2_mem_rdata = 'x; #1;
    n_checks++;
    if (i_pmem_resp !== 1'b0 || d_pmem_resp !== 1'b0 || l2_mem_read !== 1'b0 || l2_mem_write !== 1'b0) begin
      n_fails++; $display("FAIL spurious_no_resp: got ir=%b dr=%b rd=%b wr=%b expected 0 0 0 0", i_pmem_resp, d_pmem_resp, l2_mem_read, l2_mem_write);
    end
    @(negedge clk); l2_mem_resp = 0; l2_mem_rdata = '0; #1;
    n_checks++;
    if (i_pmem_rdata !== last || d_pmem_rdata !== last || i_pmem_resp !== 1'b0 || d_pmem_resp !== 1'b0) begin
      n_fails++; $display("FAIL spurious_rdata_kept: got i=%h d=%h expected %h", i_pmem_rdata, d_pmem_rdata, last);
    end
    // Still IDLE: a fresh request is served with minimum latency
    serve(0, 0, 1, 0, 0, de, o);
    n_checks++;
    if (o.rd !== 1'b1 || o.sel !== 1'b1 || o.dresp !== 1'b1 || o.drdata !== de) begin
      n_fails++; $display("FAIL spurious_then_serve: got rd=%b sel=%b dr=%b data=%h expected 1 1 1 %h", o.rd, o.sel, o.dresp, o.drdata, de);
    end
    idle_cycle();
  endtask

  // Random traffic on the round-robin instance against a transaction model
  task automatic test_random();
    int            owner = -1;     // cache currently holding L2: -1 none, 0 I, 1 D
    bit            resp_due = 0;   // completion pulse owed this cycle
    int            done_owner = 0;
    bit            last_d = 0;
    int            lat_left = 0;
    logic [DW-1:0] m_rdata = '0;
    bit            i_req = 0, i_wr = 0, d_req = 0, d_wr = 0, i_got = 0, d_got = 0;
    bit            resp_now;
    logic          e_rd, e_wr, e_sel, e_ir, e_dr;
    int            winner;
    int            errs = 0;
    @(negedge clk); reset_n = 0;
    i_pmem_read = 0; i_pmem_write = 0; d_pmem_read = 0; d_pmem_write = 0; l2_mem_resp = 0;
    @(negedge clk); reset_n = 1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (i_got) begin i_req = ($urandom % 2) == 1; i_wr = ($urandom % 2) == 1; end
      else if (!i_req && ($urandom % 3) == 0) begin i_req = 1; i_wr = ($urandom % 2) == 1; end
      if (d_got) begin d_req = ($urandom % 2) == 1; d_wr = ($urandom % 2) == 1; end
      else if (!d_req && ($urandom % 3) == 0) begin d_req = 1; d_wr = ($urandom % 2) == 1; end
      i_pmem_read = i_req && !i_wr; i_pmem_write = i_req && i_wr;
      d_pmem_read = d_req && !d_wr; d_pmem_write = d_req && d_wr;
      resp_now = 0;
      if (owner >= 0) begin
        if (lat_left == 0) resp_now = 1; else lat_left--;
      end else if (($urandom % 6) == 0) begin
        resp_now = 1;
      end
      l2_mem_resp  = resp_now;
      l2_mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      #1;
      e_rd  = (owner == 0) ? (i_req && !i_wr) : (owner == 1) ? (d_req && !d_wr) : 1'b0;
      e_wr  = (owner == 0) ? (i_req && i_wr)  : (owner == 1) ? (d_req && d_wr)  : 1'b0;
      e_sel = last_d;
      e_ir  = resp_due && done_owner == 0;
      e_dr  = resp_due && done_owner == 1;
      n_checks++;
      if ({l2_mem_read, l2_mem_write, arbiter_sel, i_pmem_resp, d_pmem_resp} !== {e_rd, e_wr, e_sel, e_ir, e_dr}) begin
        n_fails++; errs++;
        if (errs <= 10) $display("FAIL random_ctrl cyc%0d: got rd,wr,sel,ir,dr=%b expected %b", cyc,
          {l2_mem_read, l2_mem_write, arbiter_sel, i_pmem_resp, d_pmem_resp}, {e_rd, e_wr, e_sel, e_ir, e_dr});
      end
      n_checks++;
      if (i_pmem_rdata !== m_rdata || d_pmem_rdata !== m_rdata) begin
        n_fails++; errs++;
        if (errs <= 10) $display("FAIL random_rdata cyc%0d: got %h expected %h", cyc, i_pmem_rdata, m_rdata);
      end
      i_got = e_ir; d_got = e_dr;
      if (resp_due) begin
        resp_due = 0;
      end else if (owner >= 0) begin
        if (resp_now) begin
          m_rdata = l2_mem_rdata; resp_due = 1; done_owner = owner; owner = -1;
        end
      end else begin
        if (i_req && d_req) winner = last_d ? 0 : 1;
        else if (d_req)     winner = 1;
        else if (i_req)     winner = 0;
        else                winner = -1;
        if (winner >= 0) begin
          owner = winner; last_d = (winner == 1); lat_left = $urandom % 4;
        end
      end
    end
    idle_cycle();
  endtask

  initial begin
    test_reset();
    test_single_i_read();
    test_tie_rr();
    test_tie_fixed();
    test_fastest();
    test_spurious_resp();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
